// File: rtl/sp_buf_arb_192x128_pkg.sv
// Shared geometry constants and the write-queue entry type for the 192x128 buffer arbiter.
package sp_buf_arb_192x128_pkg;

    localparam int SP_BUF_ADR_WD = 8;
    localparam int SP_BUF_DAT_WD = 128;
    localparam int SP_BUF_DEPTH  = 192;

    typedef struct packed {
        logic [SP_BUF_ADR_WD-1:0] adr;
        logic [SP_BUF_DAT_WD-1:0] msk;
        logic [SP_BUF_DAT_WD-1:0] dat;
    } wr_entry_t;

endpackage

// File: rtl/sp_buf_arb_192x128_wq.sv
// Small circular write queue (2 or 4 entries) with a parallel address compare
// across all valid entries, used for read-after-write hazard detection.
module sp_buf_wq
    import sp_buf_arb_192x128_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  wr_entry_t                push_entry_i,
    input  logic                     pop_i,
    output wr_entry_t                head_o,
    output logic [2:0]               count_o,
    input  logic [SP_BUF_ADR_WD-1:0] cmp_adr_i,
    output logic                     hit_o
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;

    wr_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wp_q, rp_q;
    logic [2:0]       cnt_q;
    logic [DEPTH-1:0] hit_vec;

    always_comb begin
        vld_d = vld_q;
        if (pop_i)  vld_d[rp_q] = 1'b0;
        if (push_i) vld_d[wp_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + 1'b1;
            if (pop_i)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + {2'b00, push_i} - {2'b00, pop_i};
            vld_q <= vld_d;
        end
    end

    // Entry storage needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= push_entry_i;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign hit_vec[gi] = vld_q[gi] && (mem_q[gi].adr == cmp_adr_i);
        end
    endgenerate

    assign hit_o   = |hit_vec;
    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/sp_buf_arb_192x128.sv
// Single-port arbiter for the 192x128 bit-enable buffer: queued writes, same-cycle reads,
// starvation guard and a two-cycle read return. Define SP_ARB_STAT_EN for the stall counter.
module sp_buf_arb_192x128
    import sp_buf_arb_192x128_pkg::*;
#(
    parameter int WQ_DEPTH   = 2,
    parameter int STARVE_MAX = 8,
    parameter int ADR_MAX    = SP_BUF_DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_val_i,
    output logic                     wr_rdy_o,
    input  logic [SP_BUF_ADR_WD-1:0] wr_adr_i,
    input  logic [SP_BUF_DAT_WD-1:0] wr_msk_i,
    input  logic [SP_BUF_DAT_WD-1:0] wr_dat_i,
    input  logic                     rd_val_i,
    output logic                     rd_rdy_o,
    input  logic [SP_BUF_ADR_WD-1:0] rd_adr_i,
    output logic                     rd_dat_val_o,
    output logic [SP_BUF_DAT_WD-1:0] rd_dat_o,
    output logic [SP_BUF_ADR_WD-1:0] ram_adr_o,
    output logic [SP_BUF_DAT_WD-1:0] ram_wr_ena_o,
    output logic [SP_BUF_DAT_WD-1:0] ram_wr_dat_o,
    output logic                     ram_rd_ena_o,
    input  logic [SP_BUF_DAT_WD-1:0] ram_rd_dat_i,
`ifdef SP_ARB_STAT_EN
    output logic [15:0]              stat_stall_o,
`endif
    output logic                     idle_o,
    output logic                     err_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SP_BUF_ADR_WD-1:0] ADR_LIM = ADR_MAX[SP_BUF_ADR_WD-1:0];
    localparam logic [SW-1:0] STARVE_LIM = STARVE_MAX[SW-1:0];

    wr_entry_t                wq_head;
    logic [2:0]               wq_count;
    logic                     wq_hit, wq_full, wq_empty;
    logic                     wr_push, drain, rd_fire, rd_oor, wr_oor, head_oor;
    logic [SW-1:0]            starve_q, starve_d;
    logic [SP_BUF_ADR_WD-1:0] ram_adr_q;
    logic                     p1_val_q, p1_oor_q, rd_dat_val_q, err_q, err_d;
    logic [SP_BUF_DAT_WD-1:0] rd_dat_q, rd_dat_d;

    assign wq_full  = (wq_count == 3'(WQ_DEPTH));
    assign wq_empty = (wq_count == 3'd0);
    assign wr_rdy_o = !wq_full;
    assign wr_push  = wr_val_i && wr_rdy_o;
    assign rd_oor   = rd_adr_i > ADR_LIM;
    assign wr_oor   = wr_adr_i > ADR_LIM;
    assign head_oor = wq_head.adr > ADR_LIM;

    sp_buf_wq #(.DEPTH(WQ_DEPTH)) u_wq (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (wr_push),
        .push_entry_i ('{adr: wr_adr_i, msk: wr_msk_i, dat: wr_dat_i}),
        .pop_i        (drain),
        .head_o       (wq_head),
        .count_o      (wq_count),
        .cmp_adr_i    (rd_adr_i),
        .hit_o        (wq_hit)
    );

    // Reads win the port unless a queued write is forced out by fullness, age or a hazard.
    assign drain    = !wq_empty && (!rd_val_i || wq_full || (starve_q >= STARVE_LIM) || wq_hit);
    assign rd_rdy_o = !drain;
    assign rd_fire  = rd_val_i && !drain;

    always_comb begin
        ram_rd_ena_o = 1'b1;
        ram_wr_ena_o = '0;
        ram_wr_dat_o = wq_head.dat;
        ram_adr_o    = ram_adr_q;
        if (drain) begin
            ram_rd_ena_o = 1'b0;
            ram_adr_o    = wq_head.adr;
            ram_wr_ena_o = head_oor ? '0 : wq_head.msk;
        end else if (rd_fire && !rd_oor) begin
            ram_adr_o = rd_adr_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (drain)
            starve_d = '0;
        else if (!wq_empty && (starve_q < STARVE_LIM))
            starve_d = starve_q + 1'b1;
    end

    assign err_d    = err_q || (wr_push && wr_oor) || (rd_fire && rd_oor);
    assign rd_dat_d = p1_val_q ? (p1_oor_q ? '0 : ram_rd_dat_i) : rd_dat_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q     <= '0;
            ram_adr_q    <= '0;
            p1_val_q     <= 1'b0;
            p1_oor_q     <= 1'b0;
            rd_dat_val_q <= 1'b0;
            rd_dat_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            ram_adr_q    <= ram_adr_o;
            p1_val_q     <= rd_fire;
            p1_oor_q     <= rd_oor;
            rd_dat_val_q <= p1_val_q;
            rd_dat_q     <= rd_dat_d;
            err_q        <= err_d;
        end
    end

    assign rd_dat_val_o = rd_dat_val_q;
    assign rd_dat_o     = rd_dat_q;
    assign err_o        = err_q;
    assign idle_o       = wq_empty && !p1_val_q;

`ifdef SP_ARB_STAT_EN
    logic [15:0] stat_q, stat_d;

    assign stat_d = (rd_val_i && !rd_rdy_o && (stat_q != 16'hFFFF)) ? stat_q + 16'd1 : stat_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_stall_o = stat_q;
`endif

endmodule

// File: tb/tb_sp_buf_arb_192x128.sv
// Directed bench for sp_buf_arb_192x128 with a behavioural bit-enable RAM model on the RAM port.
module tb_sp_buf_arb_192x128;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wr_val, wr_rdy, rd_val, rd_rdy, rd_dat_val, ram_rd_ena, idle, err;
    logic [7:0]   wr_adr, rd_adr, ram_adr;
    logic [127:0] wr_msk, wr_dat, rd_dat, ram_wr_ena, ram_wr_dat, ram_rd_dat;
`ifdef SP_ARB_STAT_EN
    logic [15:0]  stat_stall;
`endif
    logic [127:0] ram_mem [192];
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] A5   = {16{8'hA5}};

    always #5 clk = ~clk;

    sp_buf_arb_192x128 dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_val_i     (wr_val),
        .wr_rdy_o     (wr_rdy),
        .wr_adr_i     (wr_adr),
        .wr_msk_i     (wr_msk),
        .wr_dat_i     (wr_dat),
        .rd_val_i     (rd_val),
        .rd_rdy_o     (rd_rdy),
        .rd_adr_i     (rd_adr),
        .rd_dat_val_o (rd_dat_val),
        .rd_dat_o     (rd_dat),
        .ram_adr_o    (ram_adr),
        .ram_wr_ena_o (ram_wr_ena),
        .ram_wr_dat_o (ram_wr_dat),
        .ram_rd_ena_o (ram_rd_ena),
        .ram_rd_dat_i (ram_rd_dat),
`ifdef SP_ARB_STAT_EN
        .stat_stall_o (stat_stall),
`endif
        .idle_o       (idle),
        .err_o        (err)
    );

    // RAM model: registered read, per-bit write enable, cleared while reset is held.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 192; i++) ram_mem[i] <= '0;
            ram_rd_dat <= '0;
        end else if (ram_rd_ena) begin
            ram_rd_dat <= (ram_adr < 8'd192) ? ram_mem[ram_adr] : '0;
        end else if (ram_adr < 8'd192) begin
            ram_mem[ram_adr] <= (ram_mem[ram_adr] & ~ram_wr_ena) | (ram_wr_dat & ram_wr_ena);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [127:0] m, input logic [127:0] d);
        wr_val = 1'b1; wr_adr = a; wr_msk = m; wr_dat = d;
    endtask

    initial begin
        rstn = 1'b0; wr_val = 0; wr_adr = 0; wr_msk = 0; wr_dat = 0; rd_val = 0; rd_adr = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd_dat_val", rd_dat_val, 0); chk("rst_rd_dat", rd_dat, 0);
        chk("rst_err", err, 0);               chk("rst_idle", idle, 1);
        chk("rst_ram_rd_ena", ram_rd_ena, 1); chk("rst_ram_wr_ena", ram_wr_ena, 0);
        chk("rst_ram_adr", ram_adr, 0);       chk("rst_wr_rdy", wr_rdy, 1);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            chk("idle_rd_dat_val", rd_dat_val, 0); chk("idle_idle", idle, 1);
            chk("idle_ram_wr_ena", ram_wr_ena, 0);
        end
        $display("txn: reset and idle done");

        // Hazard: queued write to 0x05 drains before the read of 0x05
        cyc(); wr(8'h05, ONES, A5); rd_val = 0; #1;
        chk("haz_wr_rdy", wr_rdy, 1);
        cyc(); wr_val = 0; rd_val = 1; rd_adr = 8'h05; #1;
        chk("haz_rd_rdy_stall", rd_rdy, 0); chk("haz_ram_rd_ena", ram_rd_ena, 0);
        chk("haz_ram_adr", ram_adr, 8'h05); chk("haz_ram_wr_ena", ram_wr_ena, ONES);
        chk("haz_ram_wr_dat", ram_wr_dat, A5);
        cyc(); #1;
        chk("haz_rd_rdy", rd_rdy, 1); chk("haz_rd_adr", ram_adr, 8'h05); chk("haz_rd_ena", ram_rd_ena, 1);
        cyc(); rd_val = 0; #1;
        chk("haz_val_t1", rd_dat_val, 0); chk("haz_idle_t1", idle, 0);
        cyc(); #1;
        chk("haz_val_t2", rd_dat_val, 1); chk("haz_dat_t2", rd_dat, A5); chk("haz_idle_t2", idle, 1);
        $display("txn: write 0x05 then hazard read 0x05");

        // Starvation: one queued write against a continuous read stream
        cyc(); wr(8'h40, ONES, 128'h1234); rd_val = 1; rd_adr = 8'h10; #1;
        chk("stv_rd_rdy_0", rd_rdy, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(); wr_val = 0; rd_adr = 8'(8'h10 + k); #1;
            chk($sformatf("stv_rd_rdy_%0d", k), rd_rdy, (k != 9));
            if (k == 9) begin
                chk("stv_drain_adr", ram_adr, 8'h40); chk("stv_drain_rd_ena", ram_rd_ena, 0);
            end
        end
        cyc(); rd_val = 0;
        cyc(); cyc();
        $display("txn: starvation drain of write 0x40");

        // Same-cycle read and write to one address: read sees pre-write data
        wr(8'h40, ONES, 128'h5678); rd_val = 1; rd_adr = 8'h40; #1;
        chk("same_rd_rdy", rd_rdy, 1);
        cyc(); wr_val = 0; rd_val = 0; #1;
        chk("same_drain", ram_rd_ena, 0);
        cyc(); #1;
        chk("same_val", rd_dat_val, 1); chk("same_dat", rd_dat, 128'h1234);
        $display("txn: same-cycle read/write 0x40");

        // Queue fill with reads held high
        cyc(); wr(8'h50, ONES, 128'h1); rd_val = 1; rd_adr = 8'h30; #1;
        chk("fill_wr_rdy_0", wr_rdy, 1); chk("fill_rd_rdy_0", rd_rdy, 1);
        cyc(); wr(8'h51, ONES, 128'h2); rd_adr = 8'h31; #1;
        chk("fill_wr_rdy_1", wr_rdy, 1); chk("fill_rd_rdy_1", rd_rdy, 1);
        cyc(); wr_val = 0; rd_adr = 8'h32; #1;
        chk("fill_wr_rdy_full", wr_rdy, 0); chk("fill_rd_rdy_full", rd_rdy, 0);
        chk("fill_drain_adr", ram_adr, 8'h50);
        cyc(); #1;
        chk("fill_wr_rdy_rec", wr_rdy, 1); chk("fill_rd_rdy_rec", rd_rdy, 1);
        cyc(); rd_val = 0; #1;
        chk("fill_drain2_ena", ram_rd_ena, 0); chk("fill_drain2_adr", ram_adr, 8'h51);
        chk("fill_drain2_dat", ram_wr_dat, 128'h2);
        cyc(); #1;
        chk("fill_idle", idle, 1);
        $display("txn: queue fill and forced drain");

        // Masked merge at 0x20
        cyc(); wr(8'h20, ONES, ONES); rd_val = 0;
        cyc(); wr(8'h20, {8{16'h00FF}}, 128'h0); #1;
        chk("mrg_wr_rdy", wr_rdy, 1); chk("mrg_drain1_adr", ram_adr, 8'h20);
        chk("mrg_drain1_ena", ram_wr_ena, ONES);
        cyc(); wr_val = 0; rd_val = 1; rd_adr = 8'h20; #1;
        chk("mrg_rd_stall", rd_rdy, 0); chk("mrg_drain2_ena", ram_wr_ena, {8{16'h00FF}});
        cyc(); #1;
        chk("mrg_rd_rdy", rd_rdy, 1);
        cyc(); rd_val = 0;
        cyc(); #1;
        chk("mrg_val", rd_dat_val, 1); chk("mrg_dat", rd_dat, {8{16'hFF00}});
`ifdef SP_ARB_STAT_EN
        chk("stat_stall", stat_stall, 16'd4);
`endif
        $display("txn: masked merge read 0x20");

        // Out-of-range read and write
        cyc(); rd_val = 1; rd_adr = 8'hC0; #1;
        chk("oor_rd_rdy", rd_rdy, 1); chk("oor_err_pre", err, 0);
        cyc(); rd_val = 0; #1;
        chk("oor_err_set", err, 1); chk("oor_val_t1", rd_dat_val, 0);
        cyc(); #1;
        chk("oor_val_t2", rd_dat_val, 1); chk("oor_dat_t2", rd_dat, 0); chk("oor_err_hold", err, 1);
        cyc(); wr(8'hC5, ONES, ONES);
        cyc(); wr_val = 0; #1;
        chk("oorw_rd_ena", ram_rd_ena, 0); chk("oorw_wr_ena", ram_wr_ena, 0);
        cyc(); #1;
        chk("oorw_err", err, 1); chk("oorw_idle", idle, 1);
        $display("txn: out-of-range read 0xC0 and write 0xC5");

        // Reset with two queued writes and a read in flight
        cyc(); wr(8'h60, ONES, ONES); rd_val = 1; rd_adr = 8'h61;
        cyc(); wr(8'h62, ONES, ONES); rd_adr = 8'h63; #1;
        chk("mrst_rd_rdy", rd_rdy, 1);
        cyc(); wr_val = 0; rd_val = 0; #1;
        chk("mrst_full", wr_rdy, 0);
        rstn = 1'b0; #1;
        chk("mrst_idle", idle, 1);       chk("mrst_wr_rdy", wr_rdy, 1);
        chk("mrst_err", err, 0);         chk("mrst_val", rd_dat_val, 0);
        chk("mrst_wr_ena", ram_wr_ena, 0); chk("mrst_rd_ena", ram_rd_ena, 1);
`ifdef SP_ARB_STAT_EN
        chk("mrst_stat", stat_stall, 16'd0);
`endif
        cyc(); rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("post_rst_val", rd_dat_val, 0); chk("post_rst_wr_ena", ram_wr_ena, 0);
        end
        $display("txn: reset mid-queue");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sp_buf_arb_192x128.md
Name: sp_buf_arb_192x128

Overview:
- Access arbiter and scheduler sitting directly upstream of the 192x128 single-port bit-enable buffer RAM.
- Merges an independent write stream (bit-masked) and read stream onto the one RAM port.
- Queues writes, preserves read-after-write ordering and prevents write starvation.
- Registers RAM read data and returns it with fixed latency.

Parameters:
- WQ_DEPTH, 2, write-queue entries (2 or 4).
- STARVE_MAX, 8, cycles a queued write may wait before it forcibly wins the port.
- ADR_MAX, 191, highest legal word address.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active low
- wr_val_i  in  1  write request valid
- wr_rdy_o  out  1  write request accepted when wr_val_i & wr_rdy_o
- wr_adr_i  in  8  write word address
- wr_msk_i  in  128  per-bit write enable, high active
- wr_dat_i  in  128  write data
- rd_val_i  in  1  read request valid
- rd_rdy_o  out  1  read request accepted when rd_val_i & rd_rdy_o
- rd_adr_i  in  8  read word address
- rd_dat_val_o  out  1  read data valid, one-cycle pulse, no backpressure
- rd_dat_o  out  128  read data
- ram_adr_o  out  8  RAM address
- ram_wr_ena_o  out  128  RAM per-bit write enable, high active
- ram_wr_dat_o  out  128  RAM write data
- ram_rd_ena_o  out  1  1 = read cycle, 0 = write cycle
- ram_rd_dat_i  in  128  RAM read data, valid the cycle after a read
- idle_o  out  1  queue empty and no read in flight
- err_o  out  1  sticky: an out-of-range address was accepted

Behaviour:
- Reset (async, rstn low):
  - queue empty, starve counter 0, read pipeline cleared.
  - rd_dat_val_o = 0, rd_dat_o = 0, err_o = 0, idle_o = 1.
  - ram_rd_ena_o = 1, ram_wr_ena_o = 0, ram_adr_o = 0.
  - A reset mid-operation discards queued writes and in-flight reads with no output pulse.
- Write acceptance:
  - wr_rdy_o = (count < WQ_DEPTH), derived from registered state only. No same-cycle pass-through.
  - An accepted write enters the queue tail and is visible for drain from the next cycle.
- Drain condition: the queue head drains (ram_rd_ena_o = 0, ram_wr_ena_o = mask, address and data from the head) when the queue is non-empty and any of the following holds:
  - rd_val_i is low;
  - the queue is full;
  - starve_cnt >= STARVE_MAX;
  - rd_adr_i matches any valid queue entry (hazard).
- Read grant:
  - rd_rdy_o = !drain. A read is issued combinationally the same cycle (ram_rd_ena_o = 1, ram_adr_o = rd_adr_i).
- Idle cycles: ram_rd_ena_o = 1, ram_wr_ena_o = 0, ram_adr_o holds its previous value.
- Starve counter:
  - Increments, saturating, each cycle the queue is non-empty and the head is not drained.
  - Clears on drain.
- Read latency: a read accepted in cycle T gives RAM data at T+1, which is registered to rd_dat_o with rd_dat_val_o high at T+2. Reads are fully pipelined, one per cycle.
- Ordering:
  - Writes retire in FIFO order.
  - A read to an address with a pending queued write stalls until all matching entries retire, so it returns post-write data.
  - A read and a write to the same address accepted in the same cycle: the read is ordered first and returns pre-write data.
- Out-of-range addresses (> ADR_MAX), sets err_o in both cases:
  - Writes are accepted and dropped at drain; the drain cycle still consumes the port, with ram_wr_ena_o = 0.
  - Reads are accepted, the RAM is not addressed, and zeros are returned at T+2.
- err_o clears only on reset.
- rd_dat_o holds its last value when rd_dat_val_o is low.

Optional Feature:
- SP_ARB_STAT_EN defined:
  - Adds output stat_stall_o [16], counting cycles with rd_val_i & !rd_rdy_o.
  - Saturates at 0xFFFF and resets to 0.
- SP_ARB_STAT_EN undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - RAM geometry constants (SP_BUF_ADR_WD = 8, SP_BUF_DAT_WD = 128, SP_BUF_DEPTH = 192).
  - Write-entry typedef {adr, msk, dat}.
- Sub-module sp_buf_wq: WQ_DEPTH-entry write queue with push/pop, count, and a parallel address-compare hit output.
- Arbitration, starve counter and read pipeline live in the top level.

Test Plan:
- Reset then idle:
  - rd_dat_val_o = 0, idle_o = 1, ram_wr_ena_o = 0 for 10 cycles.
  - Assert rstn low mid-queue with 2 entries -> queue cleared, idle_o = 1 immediately.
- Write adr 0x05 mask all-ones data 0xA5..A5, then read 0x05 -> write drains first (hazard), read returns 0xA5..A5 with rd_dat_val_o exactly 2 cycles after rd accept.
- Continuous reads to 0x10..0x1F with one queued write to 0x40 -> reads win for 8 cycles, then the write drains on cycle 9 (STARVE_MAX = 8), rd_rdy_o low that cycle only.
- Fill the queue with 2 writes while rd_val_i is held high -> wr_rdy_o drops at count 2, drain forced, wr_rdy_o recovers the next cycle.
- Masked merge:
  - Write 0x20 all-ones, then write 0x20 mask 0x00FF..00FF data 0.
  - Read 0x20 returns 0xFF00..FF00.
- Read adr 0xC0 (192) -> returns 0 at T+2, err_o set and stays high. With SP_ARB_STAT_EN, stat_stall_o matches the counted stall cycles.
